mem_stage: RTL and testbench

Memory-access stage of the MIPS32 pipeline, placed directly downstream of the EX/MEM register. Consumes the EX/MEM control and data bundle, performs byte, halfword or word loads and stores against an internal data memory, and selects the write-back value. Registers the result into the MEM/WB pipeline register with stall and flush control. Flags misaligned accesses with a sticky error.

---
 rtl/mips_pkg.sv | 73 +++++++
 rtl/mem_stage_if.sv | 41 ++++
 rtl/data_mem.sv | 27 ++
 rtl/mem_stage.sv | 114 +++++++++++
 tb/tb_mem_stage.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions for the memory stage: opcodes, access sizes,
// the MEM/WB bundle and small decode helpers.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } access_size_e;

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] ir;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] mem_data;
        logic [DATA_W-1:0] wb_data;
        logic [REG_AW-1:0] write_addr;
        logic              reg_write;
    } memwb_t;

    // Unknown opcodes that still touch memory fall back to a full word.
    function automatic access_size_e decode_size(input logic [5:0] opcode);
        case (opcode)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input access_size_e sz, input logic [1:0] lane);
        case (sz)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] word,
                                                      input access_size_e sz,
                                                      input logic [1:0] lane,
                                                      input logic sign_ext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: return {{24{sign_ext & b[7]}}, b};
            SZ_HALF: return {{16{sign_ext & h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one port.
interface mem_stage_if;
    import mips_pkg::*;

    logic              istall;
    logic              iflush;
    logic [DATA_W-1:0] iPC;
    logic [DATA_W-1:0] iIR;
    logic [DATA_W-1:0] ialu_res;
    logic [DATA_W-1:0] iRS2;
    logic [REG_AW-1:0] iwrite_addr;
    logic              imem_read;
    logic              imem_write;
    logic              imem_to_reg;
    logic              ipc_to_reg;
    logic              ireg_write;

    logic [DATA_W-1:0] oPC;
    logic [DATA_W-1:0] oIR;
    logic [DATA_W-1:0] oalu_res;
    logic [DATA_W-1:0] omem_data;
    logic [DATA_W-1:0] owb_data;
    logic [REG_AW-1:0] owrite_addr;
    logic              oreg_write;
    logic              oaddr_err;

    modport master (
        output istall, iflush, iPC, iIR, ialu_res, iRS2, iwrite_addr,
               imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write,
        input  oPC, oIR, oalu_res, omem_data, owb_data, owrite_addr,
               oreg_write, oaddr_err
    );

    modport slave (
        input  istall, iflush, iPC, iIR, ialu_res, iRS2, iwrite_addr,
               imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write,
        output oPC, oIR, oalu_res, omem_data, owb_data, owrite_addr,
               oreg_write, oaddr_err
    );

endinterface

// File: rtl/data_mem.sv
// Word-organised data memory with per-byte write enables and an
// asynchronous read port; contents survive reset.
module data_mem #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS] = '{default: '0};

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS32 memory-access stage: size decode, alignment check, load extension,
// write-back select and the MEM/WB register with stall/flush.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    mem_stage_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [5:0]        opcode;
    access_size_e      size;
    logic [1:0]        lane;
    logic [AW-1:0]     word_idx;
    logic              access;
    logic              misaligned;
    logic              sign_ext;
    logic              store_en;
    logic [3:0]        mem_we;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] load_data;
    memwb_t            memwb_d;
    memwb_t            memwb_q;
    logic              addr_err_d;
    logic              addr_err_q;
    logic              unused_bits;

    always_comb begin
        opcode     = bus.iIR[31:26];
        size       = decode_size(opcode);
        lane       = bus.ialu_res[1:0];
        word_idx   = bus.ialu_res[AW+1:2];
        access     = bus.imem_read | bus.imem_write;
        misaligned = access & is_misaligned(size, lane);
        sign_ext   = (opcode == OP_LB) || (opcode == OP_LH);
    end

    // A store only commits on an edge that actually advances the pipeline.
    always_comb begin
        store_en = bus.imem_write & ~misaligned & ~reset & ~bus.iflush & ~bus.istall;
        mem_we   = store_en ? byte_enables(size, lane) : 4'b0000;
        case (size)
            SZ_BYTE: store_data = {4{bus.iRS2[7:0]}};
            SZ_HALF: store_data = {2{bus.iRS2[15:0]}};
            default: store_data = bus.iRS2;
        endcase
    end

    data_mem #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_data_mem (
        .clock   (clock),
        .we_i    (mem_we),
        .waddr_i (word_idx),
        .wdata_i (store_data),
        .raddr_i (word_idx),
        .rdata_o (rdata)
    );

    always_comb begin
        load_data = '0;
        if (bus.imem_read && !misaligned) begin
            load_data = extend_load(rdata, size, lane, sign_ext);
        end
    end

    always_comb begin
        memwb_d            = '0;
        memwb_d.pc         = bus.iPC;
        memwb_d.ir         = bus.iIR;
        memwb_d.alu_res    = bus.ialu_res;
        memwb_d.mem_data   = load_data;
        memwb_d.write_addr = bus.iwrite_addr;
        memwb_d.reg_write  = bus.ireg_write & ~misaligned;
        if (bus.ipc_to_reg) begin
            memwb_d.wb_data = bus.iPC + 32'd4;
        end else if (bus.imem_to_reg) begin
            memwb_d.wb_data = load_data;
        end else begin
            memwb_d.wb_data = bus.ialu_res;
        end
        addr_err_d = addr_err_q | misaligned;
    end

    // MEM/WB boundary: reset > flush > stall > advance.
    always_ff @(posedge clock) begin
        if (reset) begin
            memwb_q    <= '0;
            addr_err_q <= 1'b0;
        end else if (bus.iflush) begin
            memwb_q    <= '0;
        end else if (!bus.istall) begin
            memwb_q    <= memwb_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.oPC         = memwb_q.pc;
    assign bus.oIR         = memwb_q.ir;
    assign bus.oalu_res    = memwb_q.alu_res;
    assign bus.omem_data   = memwb_q.mem_data;
    assign bus.owb_data    = memwb_q.wb_data;
    assign bus.owrite_addr = memwb_q.write_addr;
    assign bus.oreg_write  = memwb_q.reg_write;
    assign bus.oaddr_err   = addr_err_q;

    assign unused_bits = ^{bus.iIR[25:0], bus.ialu_res[31:AW+2]};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a byte-array reference model predicts each
// MEM/WB output; a monitor compares after every rising edge.
module tb_mem_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  wa;
        logic        rd;
        logic        wr;
        logic        m2r;
        logic        p2r;
        logic        rw;
        logic        stall;
        logic        flush;
    } txn_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] md;
        logic [31:0] wb;
        logic [4:0]  wa;
        logic        rw;
        logic        err;
        logic        chk_md;
    } exp_t;

    logic clk;
    logic rst;
    mem_stage_if bus ();

    mem_stage #(.DEPTH_WORDS(256)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t exp_q [$];
    exp_t cur = '0;
    byte unsigned mem_m [1024];

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: byte-addressed memory, outputs as a held record.
    task automatic model_step(input txn_t t, input logic r);
        exp_t n;
        int unsigned a, nb;
        logic [5:0] op;
        logic mis, sgn;
        logic [31:0] v;
        n = cur;
        if (r) begin
            n = '0;
            n.chk_md = 1'b1;
        end else if (t.flush) begin
            n = '0;
            n.err = cur.err;
            n.chk_md = 1'b1;
        end else if (!t.stall) begin
            op  = t.ir[31:26];
            a   = t.alu & 32'h3FF;
            nb  = (op == 6'h20 || op == 6'h24 || op == 6'h28) ? 1 :
                  (op == 6'h21 || op == 6'h25 || op == 6'h29) ? 2 : 4;
            sgn = (op == 6'h20 || op == 6'h21);
            mis = (t.rd || t.wr) && ((a % nb) != 0);
            if (t.wr && !mis)
                for (int i = 0; i < nb; i++) mem_m[a+i] = 8'(t.rs2 >> (8*i));
            v = '0;
            for (int i = 0; i < nb; i++) v |= 32'(mem_m[a+i]) << (8*i);
            if (sgn && v[8*nb-1]) v |= 32'hFFFF_FFFF << (8*nb);
            n.pc = t.pc;
            n.ir = t.ir;
            n.alu = t.alu;
            n.md = (t.rd && !mis) ? v : 32'h0;
            n.wb = t.p2r ? t.pc + 32'd4 : (t.m2r ? n.md : t.alu);
            n.wa = t.wa;
            n.rw = t.rw && !mis;
            n.err = cur.err | mis;
            n.chk_md = t.rd;
        end
        cur = n;
        exp_q.push_back(n);
    endtask

    task automatic do_txn(input txn_t t, input logic r);
        @(negedge clk);
        rst             = r;
        bus.istall      = t.stall;
        bus.iflush      = t.flush;
        bus.iPC         = t.pc;
        bus.iIR         = t.ir;
        bus.ialu_res    = t.alu;
        bus.iRS2        = t.rs2;
        bus.iwrite_addr = t.wa;
        bus.imem_read   = t.rd;
        bus.imem_write  = t.wr;
        bus.imem_to_reg = t.m2r;
        bus.ipc_to_reg  = t.p2r;
        bus.ireg_write  = t.rw;
        model_step(t, r);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    function automatic txn_t mk_ld(input logic [5:0] op, input logic [31:0] a);
        txn_t t = '0;
        t.pc = 32'h0040_0100; t.ir = {op, 26'h00000A5}; t.alu = a;
        t.rd = 1'b1; t.m2r = 1'b1; t.rw = 1'b1; t.wa = 5'd8;
        return t;
    endfunction

    function automatic txn_t mk_st(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        txn_t t = '0;
        t.pc = 32'h0040_0200; t.ir = {op, 26'h0000123}; t.alu = a; t.rs2 = d;
        t.wr = 1'b1; t.wa = 5'd4;
        return t;
    endfunction

    function automatic txn_t mk_alu(input logic [31:0] v);
        txn_t t = '0;
        t.pc = 32'h0040_0300; t.ir = 32'h0085_1020; t.alu = v; t.rw = 1'b1; t.wa = 5'd9;
        return t;
    endfunction

    function automatic txn_t mk_link(input logic [31:0] pc);
        txn_t t = '0;
        t.pc = pc; t.ir = 32'h0C00_0040; t.alu = 32'h1234_0000; t.p2r = 1'b1;
        t.rw = 1'b1; t.wa = 5'd31;
        return t;
    endfunction

    function automatic logic [5:0] pick_lop(input int i);
        case (i)
            0: return 6'h20;
            1: return 6'h21;
            2: return 6'h23;
            3: return 6'h24;
            default: return 6'h25;
        endcase
    endfunction

    function automatic logic [5:0] pick_sop(input int i);
        case (i)
            0: return 6'h28;
            1: return 6'h29;
            default: return 6'h2B;
        endcase
    endfunction

    // Monitor: one prediction is consumed per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("oPC", bus.oPC, e.pc);
                cmp("oIR", bus.oIR, e.ir);
                cmp("oalu_res", bus.oalu_res, e.alu);
                if (e.chk_md) cmp("omem_data", bus.omem_data, e.md);
                cmp("owb_data", bus.owb_data, e.wb);
                cmp("owrite_addr", 32'(bus.owrite_addr), 32'(e.wa));
                cmp("oreg_write", 32'(bus.oreg_write), 32'(e.rw));
                cmp("oaddr_err", 32'(bus.oaddr_err), 32'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        txn_t t;
        logic r;
        logic [31:0] a;
        for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
        rst = 1'b1;
        bus.istall = 0; bus.iflush = 0; bus.iPC = 0; bus.iIR = 0; bus.ialu_res = 0;
        bus.iRS2 = 0; bus.iwrite_addr = 0; bus.imem_read = 0; bus.imem_write = 0;
        bus.imem_to_reg = 0; bus.ipc_to_reg = 0; bus.ireg_write = 0;

        do_txn(mk_alu(32'h5555_AAAA), 1'b1);
        do_txn(mk_alu(32'h5555_AAAA), 1'b1);
        after_edge();
        cmp("rst_wb", bus.owb_data, 32'h0);
        cmp("rst_rw", 32'(bus.oreg_write), 32'h0);
        cmp("rst_err", 32'(bus.oaddr_err), 32'h0);

        do_txn(mk_st(6'h2B, 32'h10, 32'hDEAD_BEEF), 1'b0);
        do_txn(mk_ld(6'h23, 32'h10), 1'b0);
        after_edge();
        cmp("lw_wb", bus.owb_data, 32'hDEAD_BEEF);
        cmp("lw_rw", 32'(bus.oreg_write), 32'h1);

        do_txn(mk_st(6'h28, 32'h13, 32'h0000_0080), 1'b0);
        do_txn(mk_ld(6'h20, 32'h13), 1'b0);
        after_edge();
        cmp("lb_wb", bus.owb_data, 32'hFFFF_FF80);
        do_txn(mk_ld(6'h24, 32'h13), 1'b0);
        after_edge();
        cmp("lbu_wb", bus.owb_data, 32'h0000_0080);
        do_txn(mk_ld(6'h25, 32'h12), 1'b0);
        after_edge();
        cmp("lhu_wb", bus.owb_data, 32'h0000_80AD);

        do_txn(mk_ld(6'h23, 32'h11), 1'b0);
        after_edge();
        cmp("mis_rw", 32'(bus.oreg_write), 32'h0);
        cmp("mis_md", bus.omem_data, 32'h0);
        cmp("mis_err", 32'(bus.oaddr_err), 32'h1);
        do_txn(mk_st(6'h29, 32'h11, 32'h0000_1234), 1'b0);
        do_txn(mk_ld(6'h23, 32'h10), 1'b0);
        after_edge();
        cmp("sh_mis_mem", bus.owb_data, 32'h80AD_BEEF);
        cmp("err_sticky", 32'(bus.oaddr_err), 32'h1);

        t = mk_st(6'h2B, 32'h20, 32'h1122_3344);
        t.stall = 1'b1;
        for (int i = 0; i < 3; i++) do_txn(t, 1'b0);
        after_edge();
        cmp("stall_hold", bus.owb_data, 32'h80AD_BEEF);
        t.stall = 1'b0;
        do_txn(t, 1'b0);
        do_txn(mk_ld(6'h23, 32'h20), 1'b0);
        after_edge();
        cmp("stall_commit", bus.owb_data, 32'h1122_3344);

        t = mk_st(6'h2B, 32'h24, 32'hCAFE_F00D);
        t.flush = 1'b1;
        do_txn(t, 1'b0);
        after_edge();
        cmp("flush_wb", bus.owb_data, 32'h0);
        cmp("flush_pc", bus.oPC, 32'h0);
        t.stall = 1'b1;
        do_txn(t, 1'b0);
        do_txn(mk_ld(6'h23, 32'h24), 1'b0);
        after_edge();
        cmp("flush_nowrite", bus.owb_data, 32'h0);

        do_txn(mk_link(32'h0040_0008), 1'b0);
        after_edge();
        cmp("link_wb", bus.owb_data, 32'h0040_000C);
        do_txn(mk_link(32'hFFFF_FFFC), 1'b0);
        after_edge();
        cmp("link_wrap", bus.owb_data, 32'h0);
        do_txn(mk_alu(32'h1234_5678), 1'b0);
        after_edge();
        cmp("alu_wb", bus.owb_data, 32'h1234_5678);

        t = mk_st(6'h2B, 32'h30, 32'hAAAA_5555);
        t.stall = 1'b1;
        do_txn(t, 1'b0);
        do_txn(t, 1'b1);
        after_edge();
        cmp("rst2_wb", bus.owb_data, 32'h0);
        cmp("rst2_err", 32'(bus.oaddr_err), 32'h0);
        do_txn(mk_ld(6'h23, 32'h30), 1'b0);
        after_edge();
        cmp("rst_dropped", bus.owb_data, 32'h0);
        do_txn(mk_ld(6'h23, 32'h10), 1'b0);
        after_edge();
        cmp("mem_retained", bus.owb_data, 32'h80AD_BEEF);

        for (int n = 0; n < 400; n++) begin
            a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            case ($urandom_range(0, 5))
                0: t = mk_ld(pick_lop($urandom_range(0, 4)), a);
                1: t = mk_st(pick_sop($urandom_range(0, 2)), a, $urandom);
                2: t = mk_alu($urandom);
                3: t = mk_link($urandom & 32'hFFFF_FFFC);
                4: t = ($urandom_range(0, 1) == 0) ? mk_ld(6'h0F, a) : mk_st(6'h0F, a, $urandom);
                default: t = mk_ld(6'h23, a & 32'hFFFF_FFFC);
            endcase
            t.pc    = ($urandom_range(0, 3) == 0) ? t.pc : ($urandom & 32'hFFFF_FFFC);
            t.wa    = 5'($urandom_range(0, 31));
            t.stall = ($urandom_range(0, 99) < 12);
            t.flush = ($urandom_range(0, 99) < 6);
            r       = ($urandom_range(0, 99) < 2);
            do_txn(t, r);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        cmp("drain", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
